// File: rtl/stack_sequencer.sv
// stack_sequencer: turns one stack-machine instruction at a time into the
// PUSH/POP/REPLACE/NONE command sequence for an operand stack, then reports
// completion with a one-cycle done pulse or latches a sticky trap.
module stack_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_imm,
    output logic [1:0]       stack_op,
    output logic [WIDTH-1:0] stack_data,
    input  logic [WIDTH-1:0] stack_tos,
    input  logic [1:0]       stack_status,
    output logic             done,
    output logic             trap,
    output logic [1:0]       trap_code
);

    // Stack command encodings
    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;
    localparam logic [1:0] OP_REPLACE = 2'd3;

    // Stack status encodings
    localparam logic [1:0] ST_EMPTY     = 2'd1;
    localparam logic [1:0] ST_OVERFLOW  = 2'd2;
    localparam logic [1:0] ST_UNDERFLOW = 2'd3;

    // Instruction opcodes
    localparam logic [3:0] OPC_NOP   = 4'd0;
    localparam logic [3:0] OPC_CONST = 4'd1;
    localparam logic [3:0] OPC_DROP  = 4'd2;
    localparam logic [3:0] OPC_DUP   = 4'd3;
    localparam logic [3:0] OPC_EQZ   = 4'd4;
    localparam logic [3:0] OPC_ADD   = 4'd5;
    localparam logic [3:0] OPC_SUB   = 4'd6;
    localparam logic [3:0] OPC_AND   = 4'd7;
    localparam logic [3:0] OPC_OR    = 4'd8;
    localparam logic [3:0] OPC_XOR   = 4'd9;

    // Trap causes
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_OVERFLOW  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {StIdle, StExec, StExec2, StCheck, StTrap} state_t;

    state_t           state_q, state_d;
    logic [3:0]       opcode_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] b_q;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             trap_q;
    logic [1:0]       code_q;
    logic [1:0]       cause_q, cause_d;
    logic             is_binary;
    logic [WIDTH-1:0] alu;

    assign is_binary = (opcode_q >= OPC_ADD) && (opcode_q <= OPC_XOR);

    // Binary result: a is the entry exposed by the pop, b was latched from the old top
    always_comb begin
        alu = '0;
        unique case (opcode_q)
            OPC_ADD: alu = stack_tos + b_q;
            OPC_SUB: alu = stack_tos - b_q;
            OPC_AND: alu = stack_tos & b_q;
            OPC_OR:  alu = stack_tos | b_q;
            OPC_XOR: alu = stack_tos ^ b_q;
            default: alu = '0;
        endcase
    end

    // Next-state and combinational stack command decode
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        done_d     = 1'b0;
        stack_op   = OP_NONE;
        stack_data = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_opcode > OPC_XOR) begin
                        state_d = StTrap;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                unique case (opcode_q)
                    OPC_NOP: stack_op = OP_NONE;
                    OPC_CONST: begin
                        stack_op   = OP_PUSH;
                        stack_data = imm_q;
                    end
                    OPC_DROP: stack_op = OP_POP;
                    OPC_DUP: begin
                        stack_op   = OP_PUSH;
                        stack_data = stack_tos;
                    end
                    OPC_EQZ: begin
                        stack_op   = OP_REPLACE;
                        stack_data = {{(WIDTH-1){1'b0}}, (stack_tos == '0)};
                    end
                    default: stack_op = OP_POP;
                endcase
                state_d = is_binary ? StExec2 : StCheck;
            end
            StExec2: begin
                // EMPTY after the pop means the second operand never existed
                if (stack_status == ST_EMPTY) begin
                    state_d = StTrap;
                    cause_d = CAUSE_UNDERFLOW;
                end else begin
                    stack_op   = OP_REPLACE;
                    stack_data = alu;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (stack_status == ST_OVERFLOW) begin
                    state_d = StTrap;
                    cause_d = CAUSE_OVERFLOW;
                end else if (stack_status == ST_UNDERFLOW) begin
                    state_d = StTrap;
                    cause_d = CAUSE_UNDERFLOW;
                end else begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StTrap: state_d = StTrap;
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    // State, latched operands and registered handshake/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            opcode_q <= '0;
            imm_q    <= '0;
            b_q      <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            code_q   <= '0;
            cause_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            cause_q <= cause_d;
            // trap and its code follow the TRAP state by one register stage
            trap_q  <= (state_q == StTrap);
            code_q  <= (state_q == StTrap) ? cause_q : 2'd0;
            if (state_q == StIdle && in_valid) begin
                opcode_q <= in_opcode;
                imm_q    <= in_imm;
            end
            if (state_q == StExec) begin
                b_q <= stack_tos;
            end
        end
    end

    assign in_ready  = ready_q;
    assign done      = done_q;
    assign trap      = trap_q;
    assign trap_code = code_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a behavioural capacity-2 stack, a driver that queues
// the expected outcome of each instruction, and a monitor that checks each done
// pulse or trap assertion against the queue head.
module tb_stack_sequencer;

    localparam logic [1:0] OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_REPLACE = 2'd3;
    localparam logic [1:0] S_NONE = 2'd0, S_EMPTY = 2'd1, S_OVF = 2'd2, S_UNF = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_opcode = '0;
    logic [7:0] in_imm = '0;
    logic [1:0] stack_op;
    logic [7:0] stack_data;
    logic [7:0] stack_tos;
    logic [1:0] stack_status;
    logic       done;
    logic       trap;
    logic [1:0] trap_code;

    stack_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_imm       (in_imm),
        .stack_op     (stack_op),
        .stack_data   (stack_data),
        .stack_tos    (stack_tos),
        .stack_status (stack_status),
        .done         (done),
        .trap         (trap),
        .trap_code    (trap_code)
    );

    always #5 clk = ~clk;

    // Behavioural operand stack, capacity 2; status reflects the last non-NONE command
    logic [7:0] mem [0:1];
    logic [1:0] cnt;
    logic [1:0] st;
    assign stack_tos    = (cnt == 2'd0) ? 8'h00 : ((cnt == 2'd2) ? mem[1] : mem[0]);
    assign stack_status = st;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 2'd0;
            st  <= S_EMPTY;
        end else begin
            case (stack_op)
                OP_PUSH: begin
                    if (cnt == 2'd2) st <= S_OVF;
                    else begin
                        mem[cnt[0]] <= stack_data;
                        cnt <= cnt + 2'd1;
                        st  <= S_NONE;
                    end
                end
                OP_POP: begin
                    if (cnt == 2'd0) st <= S_UNF;
                    else begin
                        cnt <= cnt - 2'd1;
                        st  <= (cnt == 2'd1) ? S_EMPTY : S_NONE;
                    end
                end
                OP_REPLACE: begin
                    if (cnt == 2'd0) st <= S_UNF;
                    else begin
                        if (cnt == 2'd2) mem[1] <= stack_data;
                        else mem[0] <= stack_data;
                        st <= S_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        bit         is_trap;
        logic [1:0] code;
        logic [7:0] tos;
        logic [1:0] status;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   trap_prev = 1'b0;
    bit   replace_seen = 1'b0;
    bit   nonnone_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Edge counter and accept-edge timestamp for latency measurement
    always @(posedge clk) begin
        cyc++;
        if (in_valid && in_ready) acc_cyc = cyc;
    end

    // Monitor: pops an expectation on every done pulse or rising trap
    always @(negedge clk) begin
        if (!reset) begin
            trap_prev = 1'b0;
        end else begin
            if (stack_op == OP_REPLACE) replace_seen = 1'b1;
            if (stack_op != OP_NONE) nonnone_seen = 1'b1;
            if (done || (trap && !trap_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual done=%0b trap=%0b required=none",
                             done, trap);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("outcome_is_trap", {31'd0, trap}, {31'd0, mon_e.is_trap});
                    chk("tos", {24'd0, stack_tos}, {24'd0, mon_e.tos});
                    if (mon_e.is_trap) begin
                        chk("trap_code", {30'd0, trap_code}, {30'd0, mon_e.code});
                    end else begin
                        chk("status", {30'd0, stack_status}, {30'd0, mon_e.status});
                        chk("done_latency", cyc - acc_cyc, mon_e.lat);
                    end
                end
            end
            trap_prev = trap;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        replace_seen = 1'b0;
        nonnone_seen = 1'b0;
        @(negedge clk);
    endtask

    // Issue one instruction, queue its expected outcome and wait for the monitor to consume it
    task automatic issue(input logic [3:0] opc, input logic [7:0] imm, input bit is_trap,
                         input logic [1:0] code, input logic [7:0] tos, input logic [1:0] status,
                         input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        e.is_trap = is_trap;
        e.code    = code;
        e.tos     = tos;
        e.status  = status;
        e.lat     = lat;
        exp_q.push_back(e);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_imm    = imm;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("response_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_stack_op", {30'd0, stack_op}, {30'd0, OP_NONE});
        chk("rst_stack_data", {24'd0, stack_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_trap_code", {30'd0, trap_code}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 5 - 3 = 2
        issue(4'd1, 8'h05, 1'b0, 2'd0, 8'h05, S_NONE, 2);
        issue(4'd1, 8'h03, 1'b0, 2'd0, 8'h03, S_NONE, 2);
        issue(4'd6, 8'h00, 1'b0, 2'd0, 8'h02, S_NONE, 3);

        // 0xFF + 0x02 wraps to 0x01, then EQZ twice
        do_reset();
        issue(4'd1, 8'hFF, 1'b0, 2'd0, 8'hFF, S_NONE, 2);
        issue(4'd1, 8'h02, 1'b0, 2'd0, 8'h02, S_NONE, 2);
        issue(4'd5, 8'h00, 1'b0, 2'd0, 8'h01, S_NONE, 3);
        issue(4'd4, 8'h00, 1'b0, 2'd0, 8'h00, S_NONE, 2);
        issue(4'd4, 8'h00, 1'b0, 2'd0, 8'h01, S_NONE, 2);

        // Third push overflows a capacity-2 stack; trap is sticky
        do_reset();
        issue(4'd1, 8'h01, 1'b0, 2'd0, 8'h01, S_NONE, 2);
        issue(4'd1, 8'h02, 1'b0, 2'd0, 8'h02, S_NONE, 2);
        issue(4'd1, 8'h03, 1'b1, 2'd2, 8'h02, S_NONE, 0);
        in_valid  = 1'b1;
        in_opcode = 4'd1;
        in_imm    = 8'h09;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("trap_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("trap_hold_trap", {31'd0, trap}, 32'd1);
        chk("trap_hold_code", {30'd0, trap_code}, 32'd2);
        chk("trap_hold_tos", {24'd0, stack_tos}, 32'h02);
        chk("trap_hold_op", {30'd0, stack_op}, {30'd0, OP_NONE});

        // DROP on empty stack underflows
        do_reset();
        issue(4'd2, 8'h00, 1'b1, 2'd1, 8'h00, S_NONE, 0);

        // ADD with a single operand traps without ever driving REPLACE
        do_reset();
        issue(4'd1, 8'h07, 1'b0, 2'd0, 8'h07, S_NONE, 2);
        issue(4'd5, 8'h00, 1'b1, 2'd1, 8'h00, S_NONE, 0);
        chk("no_replace_on_underflow", {31'd0, replace_seen}, 32'd0);

        // Illegal opcode issues no stack command
        do_reset();
        issue(4'hF, 8'h00, 1'b1, 2'd3, 8'h00, S_NONE, 0);
        chk("illegal_no_stack_op", {31'd0, nonnone_seen}, 32'd0);

        // Reset asserted during EXEC2 of an ADD aborts immediately
        do_reset();
        issue(4'd1, 8'h01, 1'b0, 2'd0, 8'h01, S_NONE, 2);
        issue(4'd1, 8'h02, 1'b0, 2'd0, 8'h02, S_NONE, 2);
        in_valid  = 1'b1;
        in_opcode = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("exec2_op", {30'd0, stack_op}, {30'd0, OP_REPLACE});
        chk("exec2_data", {24'd0, stack_data}, 32'h03);
        reset = 1'b0;
        #1;
        chk("abort_stack_op", {30'd0, stack_op}, {30'd0, OP_NONE});
        chk("abort_stack_data", {24'd0, stack_data}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_trap", {31'd0, trap}, 32'd0);

        // Sequencer still works after the abort
        issue(4'd1, 8'h2A, 1'b0, 2'd0, 8'h2A, S_NONE, 2);
        issue(4'd3, 8'h00, 1'b0, 2'd0, 8'h2A, S_NONE, 2);
        issue(4'd9, 8'h00, 1'b0, 2'd0, 8'h00, S_NONE, 3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
